// File: rtl/output_accum_buffer.sv
// Output accumulation buffer: stores array result rows, optionally adding each
// incoming row onto the stored one, with an independent dump read port and a
// whole-buffer clear sequence.
module output_accum_buffer #(
  parameter int unsigned ARRAY_WIDTH     = 16,
  parameter int unsigned SRAM_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH      = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] in_data [ARRAY_WIDTH],
  input  logic                       in_accum,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data [ARRAY_WIDTH],
  input  logic                       clear_start,
  output logic                       clear_done,
  output logic                       busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [SRAM_DATA_WIDTH-1:0] row_t [ARRAY_WIDTH];
  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  clear_done_q;

  row_t mem [DEPTH];

  // Row accepted in cycle T sits in this stage during T+1 and commits at its end.
  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic                  s1_accum_q;
  row_t                  s1_data_q;
  row_t                  s1_stored_q;
  row_t                  s1_result;

  logic                  accept;
  logic                  fwd;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  row_t                  wr_row;

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid && in_ready;
  // The row committing this edge is not yet visible to the memory read, so bypass it.
  assign fwd        = s1_valid_q && (s1_addr_q == in_addr);
  assign busy       = (state_q != StIdle) || s1_valid_q;
  assign clear_done = clear_done_q;

  // Per-lane add or overwrite, plain two's-complement wrap.
  always_comb begin
    for (int i = 0; i < int'(ARRAY_WIDTH); i++) begin
      s1_result[i] = s1_accum_q ? (s1_stored_q[i] + s1_data_q[i]) : s1_data_q[i];
    end
  end

  // Single write port: clear rows during CLEAR, otherwise the pipe's result.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr_q;
    wr_row  = s1_result;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      for (int i = 0; i < int'(ARRAY_WIDTH); i++) begin
        wr_row[i] = '0;
      end
    end else if (s1_valid_q) begin
      wr_en = 1'b1;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_row;
    end
  end

  // Pipe datapath capture on accept, including the accumulate-side read.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q   <= in_addr;
      s1_accum_q  <= in_accum;
      s1_data_q   <= in_data;
      s1_stored_q <= fwd ? s1_result : mem[in_addr];
    end
  end

  // Pipe valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  // Dump read port: read-before-write, holds when rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ARRAY_WIDTH); i++) begin
        rd_data[i] <= '0;
      end
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Control FSM: wait for the pipe to empty, then sweep zero rows over the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!s1_valid_q) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        StClear: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q      <= StIdle;
            clear_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_output_accum_buffer.sv
// Self-checking bench for output_accum_buffer against a row-level memory model.
module tb_output_accum_buffer;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned ADW   = 10;
  localparam int unsigned DEPTH = 1024;

  typedef logic [DW-1:0] row_t [AW];
  typedef logic [AW*DW-1:0] flat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [ADW-1:0] in_addr = '0;
  row_t           in_data;
  logic           in_accum = 1'b0;
  logic           rd_en = 1'b0;
  logic [ADW-1:0] rd_addr = '0;
  row_t           rd_data;
  logic           clear_start = 1'b0;
  logic           clear_done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Model: lmem is the logical row content after every accepted write; vmem is
  // what the dump port can see (a write becomes visible two edges after accept).
  row_t           lmem [DEPTH];
  row_t           vmem [DEPTH];
  row_t           exp_rd;
  bit             pend_v = 1'b0;
  logic [ADW-1:0] pend_addr;
  row_t           pend_row;
  bit             model_idle = 1'b1;

  always #5 clk = ~clk;

  output_accum_buffer #(
    .ARRAY_WIDTH    (AW),
    .SRAM_DATA_WIDTH(DW),
    .ADDR_WIDTH     (ADW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_accum   (in_accum),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .clear_start(clear_start),
    .clear_done (clear_done),
    .busy       (busy)
  );

  function automatic flat_t pack(input row_t r);
    flat_t f;
    for (int i = 0; i < int'(AW); i++) f[i*DW +: DW] = r[i];
    return f;
  endfunction

  function automatic void zero_model();
    for (int a = 0; a < int'(DEPTH); a++) begin
      for (int i = 0; i < int'(AW); i++) begin
        lmem[a][i] = '0;
        vmem[a][i] = '0;
      end
    end
  endfunction

  // One clock edge: update the model from the inputs sampled at it, then settle.
  task automatic tick();
    row_t nr;
    @(posedge clk);
    if (!rst_n) begin
      pend_v = 1'b0;
      for (int i = 0; i < int'(AW); i++) exp_rd[i] = '0;
    end else begin
      if (rd_en) exp_rd = vmem[rd_addr];
      if (pend_v) vmem[pend_addr] = pend_row;
      pend_v = 1'b0;
      if (in_valid && model_idle) begin
        for (int i = 0; i < int'(AW); i++)
          nr[i] = in_accum ? lmem[in_addr][i] + in_data[i] : in_data[i];
        lmem[in_addr] = nr;
        pend_v    = 1'b1;
        pend_addr = in_addr;
        pend_row  = nr;
      end
    end
    #1;
  endtask

  task automatic fill_lanes(input logic [DW-1:0] v);
    for (int i = 0; i < int'(AW); i++) in_data[i] = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(AW); i++) in_data[i] = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %0b want 0", clear_done); end
    checks++;
    if (pack(rd_data) !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", pack(rd_data)); end
  endtask

  task automatic test_overwrite();
    row_t want;
    bit bad;
    in_valid = 1'b1; in_addr = 10; in_accum = 1'b0;
    for (int i = 0; i < int'(AW); i++) begin in_data[i] = 32'(i); want[i] = 32'(i); end
    tick();
    in_valid = 1'b0;
    fill_lanes($urandom());
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL overwrite_busy_inflight: got %0b want 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL overwrite_busy_done: got %0b want 0", busy); end
    rd_en = 1'b1; rd_addr = 10;
    tick();
    rd_en = 1'b0; rd_addr = 3;
    bad = 1'b0;
    for (int i = 0; i < int'(AW); i++) if (rd_data[i] !== want[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL overwrite_row10: got %h want %h", pack(rd_data), pack(want)); end
    tick();
    checks++;
    if (pack(rd_data) !== pack(want)) begin
      errors++; $display("FAIL rd_data_hold: got %h want %h", pack(rd_data), pack(want));
    end
  endtask

  task automatic test_back_to_back();
    row_t want;
    in_valid = 1'b1; in_addr = 5;
    in_accum = 1'b0; fill_lanes(1); tick();
    in_accum = 1'b1; fill_lanes(2); tick();
    in_accum = 1'b1; fill_lanes(3); tick();
    in_valid = 1'b0; in_accum = 1'b0; fill_lanes($urandom());
    tick();
    rd_en = 1'b1; rd_addr = 5; tick(); rd_en = 1'b0;
    for (int i = 0; i < int'(AW); i++) want[i] = 32'd6;
    checks++;
    if (pack(rd_data) !== pack(want)) begin
      errors++; $display("FAIL back_to_back_row5: got %h want %h", pack(rd_data), pack(want));
    end
    checks++;
    if (pack(rd_data) !== pack(exp_rd)) begin
      errors++; $display("FAIL back_to_back_model: got %h want %h", pack(rd_data), pack(exp_rd));
    end
  endtask

  task automatic test_wrap();
    row_t want;
    // Forwarded path: second write directly follows the first.
    in_valid = 1'b1; in_addr = 0; in_accum = 1'b0; fill_lanes(32'h7FFF_FFFF); tick();
    in_accum = 1'b1; fill_lanes(32'h0000_0001); tick();
    // Memory-read path: accumulate onto a row written well earlier.
    in_addr = 1; in_accum = 1'b0; fill_lanes(32'hFFFF_FFFF); tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_accum = 1'b1; fill_lanes(32'h0000_0002); tick();
    in_valid = 1'b0; tick();
    rd_en = 1'b1; rd_addr = 0; tick();
    for (int i = 0; i < int'(AW); i++) want[i] = 32'h8000_0000;
    checks++;
    if (pack(rd_data) !== pack(want)) begin
      errors++; $display("FAIL wrap_row0: got %h want %h", pack(rd_data), pack(want));
    end
    rd_addr = 1; tick(); rd_en = 1'b0;
    for (int i = 0; i < int'(AW); i++) want[i] = 32'h0000_0001;
    checks++;
    if (pack(rd_data) !== pack(want)) begin
      errors++; $display("FAIL wrap_row1: got %h want %h", pack(rd_data), pack(want));
    end
  endtask

  task automatic test_collision();
    row_t a, b;
    for (int i = 0; i < int'(AW); i++) begin a[i] = $urandom(); b[i] = $urandom(); end
    in_valid = 1'b1; in_addr = 7; in_accum = 1'b0; in_data = a; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = b; tick();
    // This edge commits b to row 7 while the dump port reads it.
    in_valid = 1'b0; rd_en = 1'b1; rd_addr = 7; tick();
    checks++;
    if (pack(rd_data) !== pack(a)) begin
      errors++; $display("FAIL collision_old: got %h want %h", pack(rd_data), pack(a));
    end
    tick(); rd_en = 1'b0;
    checks++;
    if (pack(rd_data) !== pack(b)) begin
      errors++; $display("FAIL collision_new: got %h want %h", pack(rd_data), pack(b));
    end
  endtask

  task automatic test_clear();
    int  n;
    bit  seen;
    bit  bad_ctl;
    bit  bad_rows;
    in_accum = 1'b0;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_addr = ADW'(r);
      for (int i = 0; i < int'(AW); i++) in_data[i] = $urandom() | 32'h1;
      // Last row coincides with clear_start and must still be committed first.
      clear_start = (r == 3);
      tick();
    end
    clear_start = 1'b0;
    model_idle  = 1'b0;
    n = 0; seen = 1'b0; bad_ctl = 1'b0;
    while (!seen && n < int'(DEPTH) + 16) begin
      // Traffic offered while busy must be ignored.
      in_valid = $urandom_range(0, 1); in_addr = ADW'($urandom_range(0, 3));
      in_accum = $urandom_range(0, 1); fill_lanes($urandom());
      clear_start = (n == 50);
      if (in_ready !== 1'b0 || busy !== 1'b1) bad_ctl = 1'b1;
      tick();
      n++;
      if (clear_done === 1'b1) seen = 1'b1;
    end
    in_valid = 1'b0; clear_start = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL clear_done_timeout: got none after %0d cycles want pulse", n); end
    checks++;
    if (bad_ctl) begin errors++; $display("FAIL clear_ctl: in_ready/busy wrong during clear, want 0/1"); end
    checks++;
    if (n < int'(DEPTH)) begin errors++; $display("FAIL clear_length: got %0d cycles want >= %0d", n, DEPTH); end
    tick();
    checks++;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_done_width: got %0b want 0", clear_done); end
    model_idle = 1'b1;
    zero_model();
    bad_ctl = 1'b0;
    repeat (3) begin
      if (in_ready !== 1'b1 || busy !== 1'b0) bad_ctl = 1'b1;
      tick();
    end
    checks++;
    if (bad_ctl) begin errors++; $display("FAIL clear_return_idle: in_ready/busy wrong, want 1/0"); end
    bad_rows = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_en = 1'b1; rd_addr = ADW'(a);
      tick();
      if (pack(rd_data) !== '0) begin
        bad_rows = 1'b1;
        if (a < 8) $display("FAIL clear_row%0d: got %h want 0", a, pack(rd_data));
      end
    end
    rd_en = 1'b0;
    checks++;
    if (bad_rows) errors++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = ADW'($urandom_range(0, 7));
      in_accum = $urandom_range(0, 1);
      fill_lanes(32'h0);
      for (int i = 0; i < int'(AW); i++) in_data[i] = $urandom();
      rd_en    = $urandom_range(0, 1);
      rd_addr  = ADW'($urandom_range(0, 7));
      tick();
      checks++;
      if (pack(rd_data) !== pack(exp_rd)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL random_cycle%0d: got %h want %h", c, pack(rd_data), pack(exp_rd));
      end
    end
    in_valid = 1'b0; rd_en = 1'b0;
    tick(); tick();
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = ADW'(a);
      tick();
      checks++;
      if (pack(rd_data) !== pack(lmem[a])) begin
        errors++; $display("FAIL random_final_row%0d: got %h want %h", a, pack(rd_data), pack(lmem[a]));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    bit early;
    bit bad;
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    model_idle = 1'b0;
    early = 1'b0;
    repeat (101) begin
      tick();
      if (clear_done === 1'b1) early = 1'b1;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midclear_reset_busy: got %0b want 0", busy); end
    checks++;
    if (pack(rd_data) !== '0) begin
      errors++; $display("FAIL midclear_reset_rd_data: got %h want 0", pack(rd_data));
    end
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (clear_done !== 1'b0) early = 1'b1;
      if (in_ready !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL midclear_clear_done: got pulse want none"); end
    checks++;
    if (bad) begin errors++; $display("FAIL midclear_idle: in_ready/busy wrong after reset, want 1/0"); end
    model_idle = 1'b1;
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_back_to_back();
    test_wrap();
    test_collision();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_accum_buffer.md
OUTPUT_ACCUM_BUFFER -- requirements
Module: output_accum_buffer

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 16, number of int32 lanes per row.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 32, lane width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, row address width; DEPTH = 2**ADDR_WIDTH rows.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  array result row valid.
REQ-007 SHALL have port in_ready  output  1  row accepted when in_valid && in_ready.
REQ-008 SHALL have port in_addr  input  ADDR_WIDTH  destination row.
REQ-009 SHALL have port in_data  input  SRAM_DATA_WIDTH x ARRAY_WIDTH (unpacked)  result lanes, signed.
REQ-010 SHALL have port in_accum  input  1  1 = add to stored row, 0 = overwrite.
REQ-011 SHALL have port rd_en  input  1  dump-side read strobe.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  dump-side row address.
REQ-013 SHALL have port rd_data  output  SRAM_DATA_WIDTH x ARRAY_WIDTH (unpacked)  row read, one cycle after rd_en.
REQ-014 SHALL have port clear_start  input  1  single-cycle pulse: zero whole buffer.
REQ-015 SHALL have port clear_done  output  1  single-cycle pulse when clear completes.
REQ-016 SHALL have port busy  output  1  high while any write op in flight or FSM not IDLE.

Function
REQ-017 SHALL hold DEPTH x ARRAY_WIDTH x SRAM_DATA_WIDTH storage with one write port and two synchronous read ports (accumulate, dump).
REQ-018 SHALL implement FSM states IDLE, DRAIN, CLEAR.
REQ-019 SHALL drive in_ready = 1 only in IDLE.
REQ-020 SHALL run a 2-stage write pipe: S0 at accept cycle T registers addr/data/accum and reads stored row; S1 in cycle T+1 computes result; write commits at rising edge ending T+1.
REQ-021 SHALL compute per lane: in_accum ? stored + in_data : in_data, 32-bit two's-complement wrap, no saturation.
REQ-022 SHALL forward S1 result into S0's stored operand when S1 valid and S1 addr == accepted addr (back-to-back same-row accumulate correct).
REQ-023 SHALL sustain one accepted row per cycle in IDLE.
REQ-024 SHALL return on rd_data, in cycle after rd_en, the row value as of that rd_en edge; write committing on same edge is NOT visible (read-before-write).
REQ-025 SHALL hold rd_data unchanged when rd_en low.
REQ-026 SHALL serve rd_en in every state, independent of in_valid/clear.
REQ-027 SHALL, on clear_start in IDLE, go to DRAIN; DRAIN -> CLEAR once S0 and S1 empty.
REQ-028 SHALL in CLEAR write zero row to address counter 0..DEPTH-1, one row/cycle, then pulse clear_done and return IDLE.
REQ-029 SHALL ignore clear_start outside IDLE.
REQ-030 SHALL, when clear_start and accepted in_valid coincide, commit that row first (it is zeroed by clear).
REQ-031 SHALL ignore in_addr/in_data/in_accum when not accepted.

Reset
REQ-032 SHALL on rst_n low asynchronously force FSM IDLE, pipe valids 0, clear counter 0, clear_done 0, busy 0, rd_data all 0; in_ready 1 after release.
REQ-033 SHALL NOT clear storage contents on reset; reset mid-CLEAR or mid-pipe leaves partially written rows undefined-but-stable.

Verification
REQ-034 Overwrite: row 10 lanes i = i, accum=0; rd_en addr 10 two cycles later -> rd_data[i] = i.
REQ-035 Back-to-back accumulate: row 5 data 1 accum=0, then row 5 data 2 accum=1, then row 5 data 3 accum=1 on consecutive cycles -> read row 5 lanes = 6.
REQ-036 Wrap: row 0 = 0x7FFFFFFF, accumulate 1 -> 0x80000000.
REQ-037 Clear: fill rows 0..3, clear_start -> in_ready low, busy high, clear_done after DEPTH cycles of CLEAR plus drain; all rows read 0.
REQ-038 Same-edge collision: write row 7 committing while rd_en addr 7 -> rd_data old value; next rd_en -> new value.
REQ-039 Reset mid-CLEAR: rst_n low at clear counter 100 -> IDLE, busy 0, in_ready 1, no clear_done pulse.
